// File: rtl/core_pkg.sv
// Shared types and instruction field layout for the shader-core issue stage.
package core_pkg;

    typedef enum logic [1:0] {
        ALU    = 2'b00,
        FPU    = 2'b01,
        SFU    = 2'b10,
        BRANCH = 2'b11
    } unit_e;

    typedef enum logic [1:0] {
        ISSUE   = 2'b00,
        WAIT_BR = 2'b01,
        FLUSH   = 2'b10
    } issue_state_e;

    localparam int OPC_W    = 7;
    localparam int OPC_LSB  = 0;
    localparam int DEST_LSB = 7;
    localparam int SRCA_LSB = 12;
    localparam int SRCB_LSB = 17;
    localparam int BANK_LSB = 22;

    // A single bank still needs a 1-bit select field.
    function automatic int bank_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-bank register busy bits: one set port from issue, NUM_WB clear ports from
// writeback, and combinational hazard lookups against the registered state.
module issue_scoreboard
    import core_pkg::*;
#(
    parameter  int NREGS  = 32,
    parameter  int NBANKS = 2,
    parameter  int NUM_WB = 4,
    localparam int RW     = $clog2(NREGS),
    localparam int BW     = bank_bits(NBANKS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               set_i,
    input  logic [BW-1:0]      set_bank_i,
    input  logic [RW-1:0]      set_dest_i,
    input  logic [NUM_WB-1:0]  wb_valid_i,
    input  logic [NUM_WB*RW-1:0] wb_dest_i,
    input  logic [NUM_WB*BW-1:0] wb_bank_i,
    input  logic [BW-1:0]      rd_bank_i,
    input  logic [RW-1:0]      rd_a_i,
    input  logic [RW-1:0]      rd_b_i,
    input  logic [RW-1:0]      rd_dst_i,
    output logic               busy_a_o,
    output logic               busy_b_o,
    output logic               busy_dst_o
);

    logic [NBANKS-1:0][NREGS-1:0] busy_q, busy_d;
    logic                         rd_bank_ok;

    function automatic logic bank_ok(input logic [BW-1:0] b);
        return 32'(b) < NBANKS;
    endfunction

    // Clears are applied first so a same-edge issue to the same entry wins.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (wb_valid_i[k] && bank_ok(wb_bank_i[k*BW +: BW])) begin
                busy_d[wb_bank_i[k*BW +: BW]][wb_dest_i[k*RW +: RW]] = 1'b0;
            end
        end
        if (set_i && bank_ok(set_bank_i)) begin
            busy_d[set_bank_i][set_dest_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd_bank_ok = bank_ok(rd_bank_i);
    assign busy_a_o   = rd_bank_ok & busy_q[rd_bank_i][rd_a_i];
    assign busy_b_o   = rd_bank_ok & busy_q[rd_bank_i][rd_b_i];
    assign busy_dst_o = rd_bank_ok & busy_q[rd_bank_i][rd_dst_i];

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue stage: hazard check against the scoreboard, zero-latency
// dispatch to ALU/FPU/SFU, and a hold/flush sequence around branches.
module issue_ctrl
    import core_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int LANES  = 4,
    parameter  int NREGS  = 32,
    parameter  int NBANKS = 2,
    parameter  int NUM_WB = 4,
    localparam int RW     = $clog2(NREGS),
    localparam int BW     = bank_bits(NBANKS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     instr_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic [RW-1:0]        rf_ra_o,
    output logic [RW-1:0]        rf_rb_o,
    output logic [BW-1:0]        rf_bank_o,
    output logic [OPC_W-1:0]     iss_opc_o,
    output logic [RW-1:0]        iss_dest_o,
    output logic [BW-1:0]        iss_bank_o,
    output logic                 alu_valid_o,
    input  logic                 alu_ready_i,
    output logic                 fpu_valid_o,
    input  logic                 fpu_ready_i,
    output logic                 sfu_valid_o,
    input  logic                 sfu_ready_i,
    input  logic [NUM_WB-1:0]    wb_valid_i,
    input  logic [NUM_WB*RW-1:0] wb_dest_i,
    input  logic [NUM_WB*BW-1:0] wb_bank_i,
    input  logic                 br_valid_i,
    input  logic [LANES-1:0]     br_taken_i
);

    logic [OPC_W-1:0] opc;
    logic [RW-1:0]    dest, src_a, src_b;
    logic [BW-1:0]    bank;
    unit_e            unit;
    logic             busy_a, busy_b, busy_dst, hazard, tgt_ready;
    logic             issue_set;
    logic             ready, stall, flush, alu_v, fpu_v, sfu_v;
    logic             unused_instr;
    issue_state_e     state_q, state_d;

    assign opc   = instr_i[OPC_LSB  +: OPC_W];
    assign dest  = instr_i[DEST_LSB +: RW];
    assign src_a = instr_i[SRCA_LSB +: RW];
    assign src_b = instr_i[SRCB_LSB +: RW];
    assign bank  = instr_i[BANK_LSB +: BW];
    assign unit  = unit_e'(opc[6:5]);

    assign unused_instr = ^instr_i;

    issue_scoreboard #(
        .NREGS  (NREGS),
        .NBANKS (NBANKS),
        .NUM_WB (NUM_WB)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (issue_set),
        .set_bank_i (bank),
        .set_dest_i (dest),
        .wb_valid_i (wb_valid_i),
        .wb_dest_i  (wb_dest_i),
        .wb_bank_i  (wb_bank_i),
        .rd_bank_i  (bank),
        .rd_a_i     (src_a),
        .rd_b_i     (src_b),
        .rd_dst_i   (dest),
        .busy_a_o   (busy_a),
        .busy_b_o   (busy_b),
        .busy_dst_o (busy_dst)
    );

    // Branches write no register, so their dest field is not a WAW source.
    assign hazard = busy_a | busy_b | ((unit != BRANCH) & busy_dst);

    always_comb begin
        tgt_ready = 1'b0;
        unique case (unit)
            ALU, BRANCH: tgt_ready = alu_ready_i;
            FPU:         tgt_ready = fpu_ready_i;
            SFU:         tgt_ready = sfu_ready_i;
            default:     tgt_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        alu_v     = 1'b0;
        fpu_v     = 1'b0;
        sfu_v     = 1'b0;
        issue_set = 1'b0;
        unique case (state_q)
            ISSUE: begin
                if (instr_valid_i) begin
                    if (!hazard && tgt_ready) begin
                        ready = 1'b1;
                        unique case (unit)
                            FPU:     fpu_v = 1'b1;
                            SFU:     sfu_v = 1'b1;
                            default: alu_v = 1'b1;
                        endcase
                        if (unit == BRANCH) begin
                            state_d = WAIT_BR;
                        end else begin
                            issue_set = 1'b1;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            WAIT_BR: begin
                stall = instr_valid_i;
                if (br_valid_i) begin
                    state_d = (|br_taken_i) ? FLUSH : ISSUE;
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                stall   = instr_valid_i;
                state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    // Handshake and issue outputs are forced low for the whole reset window,
    // not just after the first edge.
    assign instr_ready_o = ready & ~rst_i;
    assign stall_o       = stall & ~rst_i;
    assign flush_o       = flush & ~rst_i;
    assign alu_valid_o   = alu_v & ~rst_i;
    assign fpu_valid_o   = fpu_v & ~rst_i;
    assign sfu_valid_o   = sfu_v & ~rst_i;
    assign iss_opc_o     = rst_i ? '0 : opc;
    assign iss_dest_o    = rst_i ? '0 : dest;
    assign iss_bank_o    = rst_i ? '0 : bank;

    assign rf_ra_o   = src_a;
    assign rf_rb_o   = src_b;
    assign rf_bank_o = bank;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: a cycle-level reference model predicts
// handshake outputs and queues expected dispatches for an independent monitor.
module tb_issue_ctrl;

    localparam int NWB = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o, stall_o, flush_o;
    logic [4:0]  rf_ra_o, rf_rb_o;
    logic [0:0]  rf_bank_o;
    logic [6:0]  iss_opc_o;
    logic [4:0]  iss_dest_o;
    logic [0:0]  iss_bank_o;
    logic        alu_valid_o, alu_ready_i;
    logic        fpu_valid_o, fpu_ready_i;
    logic        sfu_valid_o, sfu_ready_i;
    logic [NWB-1:0]   wb_valid_i;
    logic [NWB*5-1:0] wb_dest_i;
    logic [NWB-1:0]   wb_bank_i;
    logic        br_valid_i;
    logic [3:0]  br_taken_i;

    issue_ctrl #(
        .WIDTH  (32),
        .LANES  (4),
        .NREGS  (32),
        .NBANKS (2),
        .NUM_WB (NWB)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .rf_ra_o       (rf_ra_o),
        .rf_rb_o       (rf_rb_o),
        .rf_bank_o     (rf_bank_o),
        .iss_opc_o     (iss_opc_o),
        .iss_dest_o    (iss_dest_o),
        .iss_bank_o    (iss_bank_o),
        .alu_valid_o   (alu_valid_o),
        .alu_ready_i   (alu_ready_i),
        .fpu_valid_o   (fpu_valid_o),
        .fpu_ready_i   (fpu_ready_i),
        .sfu_valid_o   (sfu_valid_o),
        .sfu_ready_i   (sfu_ready_i),
        .wb_valid_i    (wb_valid_i),
        .wb_dest_i     (wb_dest_i),
        .wb_bank_i     (wb_bank_i),
        .br_valid_i    (br_valid_i),
        .br_taken_i    (br_taken_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unit;
        int opc;
        int dest;
        int bank;
    } exp_t;
    exp_t q[$];

    // Reference state: busy table plus "waiting on a branch" / "flush due" flags.
    bit mb[2][32];
    bit m_wait, m_flush, m_issue;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int opc, input int d, input int sa, input int sb, input int bk);
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = opc[6:0];
        w[11:7]  = d[4:0];
        w[16:12] = sa[4:0];
        w[21:17] = sb[4:0];
        w[22]    = bk[0];
        return w;
    endfunction

    task automatic set_wb(input int p, input int d, input int bk);
        wb_valid_i[p]       = 1'b1;
        wb_dest_i[p*5 +: 5] = d[4:0];
        wb_bank_i[p]        = bk[0];
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        int opc, d, sa, sb, bk, un;
        bit haz, rdy, e_stall, e_flush;
        #1;
        opc = int'(instr_i[6:0]);
        d   = int'(instr_i[11:7]);
        sa  = int'(instr_i[16:12]);
        sb  = int'(instr_i[21:17]);
        bk  = int'(instr_i[22]);
        un  = opc / 32;
        e_stall = 0;
        e_flush = 0;
        m_issue = 0;
        if (!rst_i) begin
            if (m_flush) begin
                e_flush = 1;
                e_stall = instr_valid_i;
            end else if (m_wait) begin
                e_stall = instr_valid_i;
            end else if (instr_valid_i) begin
                haz = mb[bk][sa] || mb[bk][sb] || (un != 3 && mb[bk][d]);
                rdy = (un == 1) ? fpu_ready_i : (un == 2) ? sfu_ready_i : alu_ready_i;
                if (!haz && rdy) m_issue = 1;
                else e_stall = 1;
            end
        end
        if (m_issue) q.push_back('{un, opc, d, bk});
        chk("instr_ready", 32'(instr_ready_o), 32'(m_issue));
        chk("stall", 32'(stall_o), 32'(e_stall));
        chk("flush", 32'(flush_o), 32'(e_flush));
        chk("rf_addr", {rf_bank_o, rf_rb_o, rf_ra_o}, 32'(bk * 1024 + sb * 32 + sa));
        if (rst_i) begin
            chk("rst_iss", {iss_bank_o, iss_dest_o, iss_opc_o}, 32'd0);
        end
        @(posedge clk);
        if (rst_i) begin
            foreach (mb[b, r]) mb[b][r] = 0;
            m_wait  = 0;
            m_flush = 0;
        end else begin
            if (m_flush) begin
                m_flush = 0;
            end else if (m_wait && br_valid_i) begin
                m_wait  = 0;
                m_flush = |br_taken_i;
            end
            if (m_issue && un == 3) m_wait = 1;
            for (int k = 0; k < NWB; k++) begin
                if (wb_valid_i[k]) mb[wb_bank_i[k]][wb_dest_i[k*5 +: 5]] = 0;
            end
            if (m_issue && un != 3) mb[bk][d] = 1;
        end
        @(negedge clk);
        wb_valid_i = '0;
        br_valid_i = 1'b0;
        br_taken_i = '0;
    endtask

    // Monitor: every dispatch must match the oldest queued expectation.
    initial begin
        exp_t e;
        logic [2:0] act_v, exp_v;
        forever begin
            @(negedge clk);
            #2;
            act_v = {sfu_valid_o, fpu_valid_o, alu_valid_o};
            if (act_v != 3'b000) begin
                if (q.size() == 0) begin
                    chk("unexpected_dispatch", 32'(act_v), 32'd0);
                end else begin
                    e = q.pop_front();
                    exp_v = (e.unit == 1) ? 3'b010 : (e.unit == 2) ? 3'b100 : 3'b001;
                    chk("unit_valid", 32'(act_v), 32'(exp_v));
                    chk("iss_opc", 32'(iss_opc_o), 32'(e.opc));
                    chk("iss_dest", 32'(iss_dest_o), 32'(e.dest));
                    chk("iss_bank", 32'(iss_bank_o), 32'(e.bank));
                end
            end
        end
    end

    initial begin
        logic [31:0] cur;
        bit have;
        rst_i = 1'b1;
        instr_i = '0;
        instr_valid_i = 1'b0;
        alu_ready_i = 1'b0;
        fpu_ready_i = 1'b0;
        sfu_ready_i = 1'b0;
        wb_valid_i = '0;
        wb_dest_i = '0;
        wb_bank_i = '0;
        br_valid_i = 1'b0;
        br_taken_i = '0;
        m_wait = 0;
        m_flush = 0;
        foreach (mb[b, r]) mb[b][r] = 0;

        tick();
        tick();
        rst_i = 1'b0;
        alu_ready_i = 1'b1;
        fpu_ready_i = 1'b1;
        sfu_ready_i = 1'b1;

        instr_valid_i = 1'b1;
        instr_i = mk(7'h01, 3, 0, 0, 0); tick();
        instr_i = mk(7'h21, 4, 3, 1, 0); repeat (3) tick();
        set_wb(2, 3, 0); tick();
        tick();
        instr_valid_i = 1'b0; tick();

        instr_valid_i = 1'b1;
        instr_i = mk(7'h02, 5, 1, 2, 0); tick();
        instr_i = mk(7'h03, 6, 5, 1, 1); tick();

        instr_i = mk(7'h04, 7, 1, 2, 0); set_wb(0, 7, 0); tick();
        instr_i = mk(7'h22, 8, 7, 1, 0); repeat (2) tick();
        set_wb(1, 7, 0); tick();
        tick();

        instr_i = mk(7'h60, 0, 1, 2, 0); tick();
        instr_i = mk(7'h05, 9, 1, 2, 0); repeat (2) tick();
        br_valid_i = 1'b1; br_taken_i = 4'b0100; tick();
        tick();
        tick();

        instr_i = mk(7'h61, 0, 1, 2, 1); tick();
        instr_i = mk(7'h06, 11, 1, 2, 1); tick();
        br_valid_i = 1'b1; br_taken_i = 4'b0000; tick();
        tick();

        sfu_ready_i = 1'b0;
        instr_i = mk(7'h40, 10, 1, 2, 0); repeat (3) tick();
        rst_i = 1'b1; tick();
        rst_i = 1'b0; sfu_ready_i = 1'b1; instr_valid_i = 1'b0; tick();
        instr_valid_i = 1'b1;
        instr_i = mk(7'h07, 12, 4, 8, 0); tick();
        instr_valid_i = 1'b0; tick();

        have = 0;
        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                cur = mk(int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 1)));
                have = 1;
            end
            instr_valid_i = have;
            instr_i = have ? cur : $urandom;
            alu_ready_i = ($urandom_range(0, 3) != 0);
            fpu_ready_i = ($urandom_range(0, 3) != 0);
            sfu_ready_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NWB; k++) begin
                if ($urandom_range(0, 9) < 3) set_wb(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
            end
            br_valid_i = ($urandom_range(0, 9) < 3);
            br_taken_i = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            rst_i = ($urandom_range(0, 499) == 0);
            tick();
            if (m_issue) have = 0;
        end

        rst_i = 1'b0;
        instr_valid_i = 1'b0;
        repeat (2) tick();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Parametrised in-order issue stage for the shader core: accepts one decoded instruction per cycle and checks RAW/WAW hazards against a per-bank register scoreboard.
- Dispatches to the ALU, FPU or SFU over valid/ready handshakes, and holds younger instructions behind an unresolved branch.
- Retires scoreboard entries from NUM_WB writeback ports and raises a one-cycle flush on a taken branch.
- Sits between fetch and the execution units. The register file is external: this block drives read addresses only.

Parameters:
- WIDTH, 32, instruction width (>=23)
- LANES, 4, SIMD lane count of branch-resolution inputs
- NREGS, 32, registers per bank (power of 2); RW = log2(NREGS)
- NBANKS, 2, register banks; BW = max(1, log2(NBANKS))
- NUM_WB, 4, independent writeback ports

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- instr_i  in  WIDTH  instruction word
- instr_valid_i  in  1  instr_i valid
- instr_ready_o  out  1  instruction accepted this cycle when high with valid
- stall_o  out  1  valid instruction held this cycle
- flush_o  out  1  one-cycle pulse, taken branch, redirect fetch
- rf_ra_o  out  RW  source A read address (combinational from instr_i)
- rf_rb_o  out  RW  source B read address
- rf_bank_o  out  BW  read bank
- iss_opc_o  out  7  issued opcode
- iss_dest_o  out  RW  issued destination
- iss_bank_o  out  BW  issued bank
- alu_valid_o / alu_ready_i  out/in  1  ALU handshake
- fpu_valid_o / fpu_ready_i  out/in  1  FPU handshake
- sfu_valid_o / sfu_ready_i  out/in  1  SFU handshake
- wb_valid_i  in  NUM_WB  writeback valid per port
- wb_dest_i  in  NUM_WB*RW  writeback destination, packed
- wb_bank_i  in  NUM_WB*BW  writeback bank, packed
- br_valid_i  in  1  branch resolved
- br_taken_i  in  LANES  per-lane taken

Behaviour:
- Field decode:
  - opc = instr[6:0]
  - dest = instr[7+:RW]
  - srcA = instr[12+:RW]
  - srcB = instr[17+:RW]
  - bank = instr[22+:BW]
  - unit = opc[6:5]: 00 ALU, 01 FPU, 10 SFU, 11 BRANCH (dispatched to ALU, no dest)
- Scoreboard: busy[NBANKS][NREGS], registered. Reset clears it to all 0.
- Hazard: busy[bank][srcA] | busy[bank][srcB] | (unit!=BRANCH & busy[bank][dest]). It reads the registered busy only, with no same-cycle writeback bypass.
- FSM:
  - ISSUE:
    - instr_valid_i & no hazard & target ready -> issue.
    - Issue means unit valid=1 and instr_ready_o=1, combinationally in the same cycle. unit valid is asserted only when ready is also high, so no holding is needed.
    - Non-branch issue sets busy[bank][dest] at the next edge.
    - BRANCH issue -> WAIT_BR.
    - Hazard or !ready -> stall_o=1, instr_ready_o=0.
  - WAIT_BR:
    - instr_ready_o=0; stall_o=instr_valid_i.
    - br_valid_i & |br_taken_i -> FLUSH.
    - br_valid_i & ~|br_taken_i -> ISSUE.
  - FLUSH: flush_o=1 for exactly one cycle, instr_ready_o=0 -> ISSUE.
- br_valid_i outside WAIT_BR is ignored.
- Writeback: each wb_valid_i[k] clears busy[wb_bank][wb_dest] at the edge. Multiple ports naming the same register are legal (clear once).
- Same-edge set (issue) and clear (writeback) of one entry: set wins.
- Reset mid-operation: FSM returns to ISSUE, busy cleared, all valid/flush/ready outputs 0.
- Output reset values:
  - instr_ready_o, stall_o, flush_o, *_valid_o = 0
  - iss_* = 0
- iss_* are driven from instr_i and only meaningful when a unit valid is high.
- Latency:
  - Issue is 0 cycles from acceptance.
  - A dependent instruction issues no earlier than the cycle after the writeback edge.

Decomposition:
- Package core_pkg holds:
  - unit_e enum (ALU, FPU, SFU, BRANCH)
  - field offset constants (OPC_LSB, DEST_LSB, SRCA_LSB, SRCB_LSB, BANK_LSB)
  - issue_state_e (ISSUE, WAIT_BR, FLUSH)
- One sub-module: issue_scoreboard. It owns busy bits, the NUM_WB clear ports, one set port, and two hazard read ports plus a dest check.

Test Plan:
- Reset then ALU op (opc=0x01, dest=r3, bank0), alu_ready_i=1 -> alu_valid_o=1 and instr_ready_o=1 same cycle; busy[0][3]=1 next cycle.
- RAW: FPU op reads r3 while busy -> stall_o=1 each cycle. wb_valid_i[2]=1 dest=3 bank=0 -> FPU issues exactly one cycle later.
- Bank isolation: busy[0][5] set, instruction bank1 srcA=r5 -> issues with no stall.
- Set/clear collision: writeback of r7 and issue of dest r7 on the same edge -> busy[0][7]=1 afterwards.
- Branch taken: BRANCH issued; held instructions stall. br_valid_i=1, br_taken_i=4'b0100 -> flush_o=1 for one cycle, then accepting again. With br_taken_i=0 -> no flush, next instruction issues the cycle after.
- SFU backpressure and reset: SFU op with sfu_ready_i=0 for 3 cycles -> sfu_valid_o=0 and stall_o=1. Assert rst_i mid-stall -> all outputs 0 and scoreboard clear.
